accum_feeder: RTL and testbench
===============================

Name: accum_feeder

Overview:
Upstream operand sequencer for the accumulator stage (ports A, S, W; S=1 loads A, S=0 adds A; the accumulator updates on every CLK edge).
- Buffers {S, A, LAST} operation entries from a producer through a valid/ready handshake.
- Issues one entry per cycle onto the accumulator's A/S inputs while RUN is high.
- Drives a no-op (A=0, S=0, i.e. add zero) on every cycle with nothing to issue.
- Pulses BATCH_DONE when the accumulator result for a LAST-terminated batch is valid on W.

Parameters:
DW, 8, operand width; matches accumulator A/W width.
DEPTH, 4, FIFO entries; power of two, at least 2.
AW, 2, log2(DEPTH).

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST_N  input  1  asynchronous active-low reset.
IN_VALID  input  1  producer offers an entry.
IN_READY  output  1  FIFO can accept an entry; combinational, equals !full.
IN_A  input  DW  operand.
IN_S  input  1  op select (1=load, 0=add).
IN_LAST  input  1  entry ends a batch.
RUN  input  1  issue enable.
A  output  DW  registered operand to the accumulator.
S  output  1  registered select to the accumulator.
BUSY  output  1  registered; high while a batch is in progress.
BATCH_DONE  output  1  registered one-cycle pulse.
COUNT  output  AW+1  FIFO occupancy, 0..DEPTH.
OP_CNT  output  8  entries issued in the current batch; wraps 255->0.

Behaviour:
- Reset (async on RST_N low):
  - A=0, S=0, BUSY=0, BATCH_DONE=0, COUNT=0, OP_CNT=0.
  - FIFO pointers cleared; contents discarded; state=IDLE.
  - Reset mid-batch abandons the batch with no BATCH_DONE.
- Push: occurs when IN_VALID & IN_READY at the edge.
  - Push while full is impossible, because IN_READY=0.
  - No bypass: an entry pushed at edge k is popped at edge k+1 at the earliest.
- Pop condition: RUN & !empty & state!=DONE.
  - Pop: A/S <= head.
  - No pop: A/S <= 0/0.
  - Latency: push at edge k -> A/S visible after edge k+1 -> accumulator W updated after edge k+2.
- Simultaneous push and pop: COUNT unchanged. When full, IN_READY stays 0 even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH. COUNT is computed from the AW+1-bit pointer difference.
- FSM states IDLE, STREAM, DONE:
  - IDLE: on pop, OP_CNT<=1 and BUSY<=1.
    - Popped entry LAST -> DONE.
    - Otherwise -> STREAM.
  - STREAM: on pop, OP_CNT+=1.
    - Popped entry LAST -> DONE.
    - No pop (RUN low or FIFO empty) -> stay; issue NOP bubble; BUSY stays 1.
  - DONE: forced bubble cycle with no pop regardless of RUN; BUSY<=0; -> IDLE.
- BATCH_DONE is registered high for exactly the one cycle after the state leaves DONE. During that cycle W holds the final batch result, since the DONE-cycle bubble adds zero. A single-entry LAST batch follows the same path.
- Back-to-back batches: a minimum of one NOP bubble separates the last op of batch n from the first op of batch n+1.
- OP_CNT holds its value in IDLE until the next batch starts.

Decomposition:
- Package accum_pkg:
  - DW default.
  - Entry struct {last, s, a[DW-1:0]}, width DW+2.
  - State enum IDLE=2'd0, STREAM=2'd1, DONE=2'd2.
  - NOP constants A=0, S=0.
- Sub-module accum_op_fifo:
  - Synchronous FIFO of DEPTH entries of DW+2 bits.
  - Same CLK/RST_N.
  - Outputs full, empty, count, head.
- accum_feeder instantiates the FIFO and holds the FSM, output registers and OP_CNT.

Test Plan:
- Basic batch: RUN=1; push (7,S=1),(3,0),(1,0),(1,0,LAST) on consecutive cycles -> A/S = 7/1,3/0,1/0,1/0 on consecutive cycles starting one cycle after the first push; then 0/0; BATCH_DONE high one cycle; downstream W=12; OP_CNT=4.
- Fill: RUN=0; push 5 entries on 5 cycles -> 4 accepted, IN_READY=0 from the cycle COUNT=4; A/S=0/0 throughout; raising RUN drains all 4 in order.
- Stall mid-batch: RUN drops for 3 cycles after the 2nd issue -> 3 NOP cycles; BUSY=1; W constant; resuming completes with the correct sum and BATCH_DONE.
- Back-to-back: batch (2,S=1,LAST) then (9,S=1),(4,0,LAST) pushed together -> exactly one bubble between batches; BATCH_DONE pulses twice; W=2 then 13.
- Async reset: assert RST_N low between clock edges during the 3rd issue -> outputs 0 immediately; COUNT=0; no BATCH_DONE; the next batch after release behaves as in the basic batch.
- Wrap: push/pop continuously for 10 entries with RUN=1 -> order preserved across pointer wrap; COUNT never exceeds 1.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulator operand feeder.
package accum_pkg;

  // Default operand width, matching the accumulator A/W width.
  localparam int DW = 8;

  // One queued operation: batch terminator, load/add select, operand.
  typedef struct packed {
    logic          last;
    logic          s;
    logic [DW-1:0] a;
  } entry_t;

  // Feeder sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Bubble issued when there is nothing to send: add zero.
  localparam logic [DW-1:0] NOP_A = '0;
  localparam logic          NOP_S = 1'b0;

endpackage

// File: rtl/accum_op_fifo.sv
// Small synchronous FIFO holding {last, s, a} operation entries.
// The head entry is read combinationally so it can be registered onto the
// accumulator inputs on the same edge that pops it.
module accum_op_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      w_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign w_count   = r_wptr - r_rptr;
  assign o_count   = w_count;
  assign o_full    = (w_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_wptr == r_rptr);
  assign o_head    = r_mem[r_rptr[AW-1:0]];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage write; contents are don't-care after reset, so no reset here.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_data;
    end
  end

  // Read/write pointers, wrapping naturally modulo 2*DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/accum_feeder.sv
// Operand sequencer in front of the accumulator: queues operations, issues
// one per cycle while RUN is high, fills idle cycles with add-zero bubbles
// and flags the cycle in which a finished batch result sits on W.
module accum_feeder
  import accum_pkg::*;
#(
  parameter int DW    = accum_pkg::DW,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [DW-1:0] IN_A,
  input  logic          IN_S,
  input  logic          IN_LAST,
  input  logic          RUN,
  output logic [DW-1:0] A,
  output logic          S,
  output logic          BUSY,
  output logic          BATCH_DONE,
  output logic [AW:0]   COUNT,
  output logic [7:0]    OP_CNT
);

  state_t        r_state;
  state_t        w_state_next;
  logic [DW-1:0] r_a;
  logic          r_s;
  logic          r_busy;
  logic          r_batch_done;
  logic [7:0]    r_op_cnt;

  logic          w_full;
  logic          w_empty;
  logic [DW+1:0] w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_head_last;
  logic          w_head_s;
  logic [DW-1:0] w_head_a;

  // IN_READY deliberately ignores a same-cycle pop: no fall-through when full.
  assign IN_READY    = ~w_full;
  assign w_push      = IN_VALID & ~w_full;
  assign w_pop       = RUN & ~w_empty & (r_state != DONE);
  assign w_head_last = w_head[DW+1];
  assign w_head_s    = w_head[DW];
  assign w_head_a    = w_head[DW-1:0];

  accum_op_fifo #(
    .WIDTH(DW + 2),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .i_clk  (CLK),
    .i_rst_n(RST_N),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data ({IN_LAST, IN_S, IN_A}),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(COUNT),
    .o_head (w_head)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state: a popped LAST closes the batch; DONE always lasts one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, STREAM: begin
        if (w_pop) w_state_next = w_head_last ? DONE : STREAM;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Registered accumulator inputs: head entry on pop, add-zero bubble otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a <= NOP_A;
      r_s <= NOP_S;
    end else if (w_pop) begin
      r_a <= w_head_a;
      r_s <= w_head_s;
    end else begin
      r_a <= NOP_A;
      r_s <= NOP_S;
    end
  end

  // Batch status: BUSY spans first pop through the DONE bubble; BATCH_DONE
  // marks the cycle after DONE, when W carries the final batch result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_busy       <= 1'b0;
      r_batch_done <= 1'b0;
    end else begin
      r_batch_done <= (r_state == DONE);
      if (r_state == DONE)                  r_busy <= 1'b0;
      else if (w_pop && r_state == IDLE)    r_busy <= 1'b1;
    end
  end

  // Per-batch issue counter; restarts at 1 on a batch's first pop and
  // holds its last value while idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_op_cnt <= '0;
    end else if (w_pop) begin
      if (r_state == IDLE) r_op_cnt <= 8'd1;
      else                 r_op_cnt <= r_op_cnt + 8'd1;
    end
  end

  assign A          = r_a;
  assign S          = r_s;
  assign BUSY       = r_busy;
  assign BATCH_DONE = r_batch_done;
  assign OP_CNT     = r_op_cnt;

endmodule

// File: tb/tb_accum_feeder.sv
// Directed bench for accum_feeder with a behavioural downstream accumulator.
module tb_accum_feeder;

  logic       CLK;
  logic       RST_N;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] IN_A;
  logic       IN_S;
  logic       IN_LAST;
  logic       RUN;
  logic [7:0] A;
  logic       S;
  logic       BUSY;
  logic       BATCH_DONE;
  logic [2:0] COUNT;
  logic [7:0] OP_CNT;
  logic [7:0] w_acc;

  int checks = 0;
  int errors = 0;

  accum_feeder #(.DW(8), .DEPTH(4), .AW(2)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_A      (IN_A),
    .IN_S      (IN_S),
    .IN_LAST   (IN_LAST),
    .RUN       (RUN),
    .A         (A),
    .S         (S),
    .BUSY      (BUSY),
    .BATCH_DONE(BATCH_DONE),
    .COUNT     (COUNT),
    .OP_CNT    (OP_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Downstream accumulator: S=1 loads A, S=0 adds A, every rising edge.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) w_acc <= 8'd0;
    else if (S) w_acc <= A;
    else        w_acc <= w_acc + A;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic s, input logic l);
    IN_VALID = v;
    IN_A     = a;
    IN_S     = s;
    IN_LAST  = l;
  endtask

  // Basic batch 7(load),3,1,1(last) with RUN=1; starts from IDLE and empty.
  task automatic basic_batch(input string p);
    RUN = 1'b1;
    drive(1, 8'd7, 1, 0); tick();
    chk({p, "_a0"}, A, 0);       chk({p, "_cnt0"}, COUNT, 1);
    drive(1, 8'd3, 0, 0); tick();
    chk({p, "_a1"}, A, 7);       chk({p, "_s1"}, S, 1);
    chk({p, "_busy1"}, BUSY, 1); chk({p, "_op1"}, OP_CNT, 1);
    drive(1, 8'd1, 0, 0); tick();
    chk({p, "_a2"}, A, 3);       chk({p, "_s2"}, S, 0);
    drive(1, 8'd1, 0, 1); tick();
    chk({p, "_a3"}, A, 1);
    drive(0, 8'd0, 0, 0); tick();
    chk({p, "_a4"}, A, 1);       chk({p, "_op4"}, OP_CNT, 4);
    chk({p, "_bd4"}, BATCH_DONE, 0);
    tick();
    chk({p, "_a5"}, A, 0);       chk({p, "_bd5"}, BATCH_DONE, 1);
    chk({p, "_w5"}, w_acc, 12);  chk({p, "_busy5"}, BUSY, 0);
    tick();
    chk({p, "_bd6"}, BATCH_DONE, 0); chk({p, "_w6"}, w_acc, 12);
    chk({p, "_op6"}, OP_CNT, 4);
  endtask

  initial begin
    RST_N = 1'b0;
    RUN   = 1'b0;
    drive(0, 8'd0, 0, 0);
    #3;
    chk("rst_a", A, 0);          chk("rst_s", S, 0);
    chk("rst_busy", BUSY, 0);    chk("rst_bd", BATCH_DONE, 0);
    chk("rst_count", COUNT, 0);  chk("rst_op", OP_CNT, 0);
    chk("rst_ready", IN_READY, 1);
    #9 RST_N = 1'b1;
    tick();

    // Basic batch
    basic_batch("basic");

    // Fill with RUN low: 10(load),20,30,40(last); fifth offer refused
    RUN = 1'b0;
    drive(1, 8'd10, 1, 0); tick(); chk("fill_c1", COUNT, 1); chk("fill_r1", IN_READY, 1);
    drive(1, 8'd20, 0, 0); tick(); chk("fill_c2", COUNT, 2);
    drive(1, 8'd30, 0, 0); tick(); chk("fill_c3", COUNT, 3); chk("fill_a3", A, 0);
    drive(1, 8'd40, 0, 1); tick(); chk("fill_c4", COUNT, 4); chk("fill_r4", IN_READY, 0);
    drive(1, 8'd50, 0, 0); tick(); chk("fill_c5", COUNT, 4); chk("fill_r5", IN_READY, 0);
    chk("fill_a5", A, 0); chk("fill_busy5", BUSY, 0);
    drive(0, 8'd0, 0, 0);
    RUN = 1'b1;
    tick(); chk("drain_a0", A, 10); chk("drain_c0", COUNT, 3); chk("drain_r0", IN_READY, 1);
    tick(); chk("drain_a1", A, 20);
    tick(); chk("drain_a2", A, 30);
    tick(); chk("drain_a3", A, 40); chk("drain_c3", COUNT, 0);
    tick(); chk("drain_bd", BATCH_DONE, 1); chk("drain_w", w_acc, 100);
    chk("drain_op", OP_CNT, 4);

    // Stall mid-batch: 5(load),6,7,8(last); RUN low for 3 cycles after 2nd issue
    RUN = 1'b0;
    drive(1, 8'd5, 1, 0); tick();
    drive(1, 8'd6, 0, 0); tick();
    drive(1, 8'd7, 0, 0); tick();
    drive(1, 8'd8, 0, 1); tick();
    drive(0, 8'd0, 0, 0);
    RUN = 1'b1;
    tick(); chk("stall_a0", A, 5);
    tick(); chk("stall_a1", A, 6);
    RUN = 1'b0;
    tick(); chk("stall_n0", A, 0); chk("stall_busy0", BUSY, 1); chk("stall_w0", w_acc, 11);
    tick(); chk("stall_n1", A, 0); chk("stall_w1", w_acc, 11);
    tick(); chk("stall_n2", A, 0); chk("stall_busy2", BUSY, 1); chk("stall_w2", w_acc, 11);
    chk("stall_op", OP_CNT, 2);
    RUN = 1'b1;
    tick(); chk("stall_a2", A, 7);
    tick(); chk("stall_a3", A, 8); chk("stall_op4", OP_CNT, 4);
    tick(); chk("stall_bd", BATCH_DONE, 1); chk("stall_w", w_acc, 26);

    // Back-to-back: 2(load,last) then 9(load),4(last)
    RUN = 1'b0;
    drive(1, 8'd2, 1, 1); tick();
    drive(1, 8'd9, 1, 0); tick();
    drive(1, 8'd4, 0, 1); tick();
    drive(0, 8'd0, 0, 0);
    RUN = 1'b1;
    tick(); chk("b2b_a0", A, 2); chk("b2b_op0", OP_CNT, 1);
    tick(); chk("b2b_bub", A, 0); chk("b2b_bd0", BATCH_DONE, 1); chk("b2b_w0", w_acc, 2);
    tick(); chk("b2b_a1", A, 9); chk("b2b_s1", S, 1); chk("b2b_bdlo", BATCH_DONE, 0);
    chk("b2b_op1", OP_CNT, 1);
    tick(); chk("b2b_a2", A, 4); chk("b2b_op2", OP_CNT, 2);
    tick(); chk("b2b_bd1", BATCH_DONE, 1); chk("b2b_w1", w_acc, 13);
    tick(); chk("b2b_bd1lo", BATCH_DONE, 0);

    // Async reset during the 3rd issue
    RUN = 1'b0;
    drive(1, 8'd1, 1, 0); tick();
    drive(1, 8'd2, 0, 0); tick();
    drive(1, 8'd3, 0, 0); tick();
    drive(1, 8'd4, 0, 1); tick();
    drive(0, 8'd0, 0, 0);
    RUN = 1'b1;
    tick(); tick(); tick();
    chk("ar_pre_a", A, 3);
    #2 RST_N = 1'b0;
    #1;
    chk("ar_a", A, 0);          chk("ar_busy", BUSY, 0);
    chk("ar_count", COUNT, 0);  chk("ar_op", OP_CNT, 0);
    chk("ar_ready", IN_READY, 1);
    RUN = 1'b0;
    tick(); chk("ar_bd0", BATCH_DONE, 0);
    tick(); chk("ar_bd1", BATCH_DONE, 0);
    #5 RST_N = 1'b1;
    tick(); chk("ar_bd2", BATCH_DONE, 0); chk("ar_a2", A, 0);
    basic_batch("post");

    // Wrap: 10 entries streamed with RUN=1, values 1..10
    RUN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(i + 1), (i == 0), (i == 9));
      tick();
      chk("wrap_cnt", COUNT, 1);
      if (i > 0) chk("wrap_a", A, i);
    end
    drive(0, 8'd0, 0, 0);
    tick(); chk("wrap_a9", A, 10); chk("wrap_c0", COUNT, 0); chk("wrap_op", OP_CNT, 10);
    tick(); chk("wrap_bd", BATCH_DONE, 1); chk("wrap_w", w_acc, 55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
